// File: rtl/step_sequencer.sv
// T0..T3 timestep sequencer with debounced single-step,
// instruction counter and 7-seg timestep display.
module step_sequencer #(
  parameter int DB_CYCLES = 500000,
  parameter int IC_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step_btn,
  input  logic            run_mode,
  input  logic            halt,
  input  logic            done,
  output logic [1:0]      tstep,
  output logic [3:0]      tstep_1h,
  output logic            advance,
  output logic [IC_W-1:0] instr_cnt,
  output logic [6:0]      hex_n
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          btn_s;
  logic          db_level;
  logic          step_pulse;
  logic [CW-1:0] db_cnt;

  logic            adv;
  logic            end_instr;
  logic [1:0]      tstep_nx;
  logic [IC_W-1:0] cnt_nx;
  logic [3:0]      oh_nx;
  logic [6:0]      hex_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= step_btn;
      btn_s <= s1;
    end
  end

  // pulse only when a new high level is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        db_level   <= btn_s;
        db_cnt     <= '0;
        step_pulse <= btn_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign adv       = !halt && (run_mode || step_pulse);
  assign end_instr = done || (tstep == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstep     <= 2'd0;
      tstep_1h  <= 4'b0001;
      advance   <= 1'b0;
      instr_cnt <= '0;
      hex_n     <= 7'b1000000;
    end else begin
      tstep     <= tstep_nx;
      tstep_1h  <= oh_nx;
      advance   <= adv;
      instr_cnt <= cnt_nx;
      hex_n     <= hex_nx;
    end
  end

  always_comb begin
    tstep_nx = tstep;
    cnt_nx   = instr_cnt;
    if (adv) begin
      if (end_instr) begin
        tstep_nx = 2'd0;
        cnt_nx   = instr_cnt + 1'b1;
      end else begin
        tstep_nx = tstep + 2'd1;
      end
    end
  end

  always_comb begin
    oh_nx  = 4'b0001 << tstep_nx;
    hex_nx = 7'b1000000;
    unique case (1'b1)
      oh_nx[0]: hex_nx = 7'b1000000;
      oh_nx[1]: hex_nx = 7'b1111001;
      oh_nx[2]: hex_nx = 7'b0100100;
      oh_nx[3]: hex_nx = 7'b0110000;
      default:  hex_nx = 7'b1000000;
    endcase
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer (DB_CYCLES=4).
// Scoreboard of expected outputs, compared 1 time unit after each edge.
module tb_step_sequencer;

  localparam int IC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            step_btn;
  logic            run_mode;
  logic            halt;
  logic            done;
  logic [1:0]      tstep;
  logic [3:0]      tstep_1h;
  logic            advance;
  logic [IC_W-1:0] instr_cnt;
  logic [6:0]      hex_n;

  typedef struct {
    logic [1:0]      ts;
    logic [3:0]      oh;
    logic            adv;
    logic [IC_W-1:0] cnt;
    logic [6:0]      hex;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  logic [1:0]      mts;
  logic [IC_W-1:0] mcnt;
  logic            madv;

  step_sequencer #(.DB_CYCLES(4), .IC_W(IC_W)) dut (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn),
    .run_mode(run_mode), .halt(halt), .done(done),
    .tstep(tstep), .tstep_1h(tstep_1h), .advance(advance),
    .instr_cnt(instr_cnt), .hex_n(hex_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hexof(input logic [1:0] t);
    case (t)
      2'd0: return 7'b1000000;
      2'd1: return 7'b1111001;
      2'd2: return 7'b0100100;
      default: return 7'b0110000;
    endcase
  endfunction

  task automatic model_adv(input logic a);
    madv = a;
    if (a) begin
      if (done || mts == 2'd3) begin
        mts  = 2'd0;
        mcnt = mcnt + 1'b1;
      end else begin
        mts = mts + 2'd1;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ts  = mts;
    e.oh  = 4'b0001 << mts;
    e.adv = madv;
    e.cnt = mcnt;
    e.hex = hexof(mts);
    q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_qempty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_tstep"}, tstep, e.ts);
    chk({tag, "_1h"}, tstep_1h, e.oh);
    chk({tag, "_adv"}, advance, e.adv);
    chk({tag, "_cnt"}, instr_cnt, e.cnt);
    chk({tag, "_hex"}, hex_n, e.hex);
  endtask

  task automatic tick(input string tag);
    model_adv(!halt && run_mode);
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic model_reset();
    mts  = 2'd0;
    mcnt = '0;
    madv = 1'b0;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    step_btn = 1'b0;
    run_mode = 1'b0;
    halt     = 1'b0;
    done     = 1'b0;
    model_reset();
    #12;
    push_exp();
    pop_cmp("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_mode = 1'b1;
    for (int i = 0; i < 8; i++) tick("free");
    chk("free_cnt2", instr_cnt, 2);
    chk("free_t0", tstep, 0);

    tick("early_a");
    done = 1'b1;
    tick("early_done1");
    chk("early_t0", tstep, 0);
    chk("early_cnt", instr_cnt, 3);
    done = 1'b0;
    for (int i = 0; i < 3; i++) tick("early_b");
    done = 1'b1;
    tick("done_t3");
    chk("done_t3_cnt", instr_cnt, 4);
    done = 1'b0;

    run_mode = 1'b0;
    for (int i = 0; i < 3; i++) tick("ss_idle");
    step_btn = 1'b1;
    tick("glitch");
    tick("glitch");
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick("glitch_after");

    step_btn = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (advance) n++;
    end
    chk("ss_adv_count", n, 1);
    model_adv(1'b1);
    madv = 1'b0;
    push_exp();
    pop_cmp("ss_press");
    chk("ss_hex1", hex_n, 7'b1111001);
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick("ss_release");

    run_mode = 1'b1;
    halt     = 1'b1;
    for (int i = 0; i < 10; i++) tick("halt_run");
    run_mode = 1'b0;
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) tick("halt_press");
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick("halt_rel");
    halt = 1'b0;
    for (int i = 0; i < 5; i++) tick("halt_noqueue");
    chk("halt_held_t", tstep, 1);
    run_mode = 1'b1;
    for (int i = 0; i < 3; i++) tick("resume");

    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    pop_cmp("midrst");
    chk("midrst_hex", hex_n, 7'b1000000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) tick("wrap");
    chk("wrap_cnt0", instr_cnt, 0);
    chk("wrap_t0", tstep, 0);
    chk("wrap_qempty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
